// File: rtl/phy_clk_gate_pkg.sv
// phy_clk_gate_pkg
//   Shared types and constants for the multi-channel PHY clock-gate controller.
//   cg_state_t   : per-channel gate state (running, stopped, waking up)
//   CG_RST_STATE : state every channel takes on reset
package phy_clk_gate_pkg;

    typedef enum {CG_ON, CG_OFF, CG_WAKE} cg_state_t;

    localparam cg_state_t CG_RST_STATE = CG_ON;

endpackage : phy_clk_gate_pkg

// File: rtl/phy_clk_gate_chan.sv
// phy_clk_gate_chan
//   One channel of the clock-gate controller: gate FSM plus a shared idle/settle
//   counter. All outputs are registered from the next-state values.
// Ports
//   clk, reset  : PHY clock, synchronous active-high reset
//   idle_limit  : idle cycles before gating, 0 disables auto-gating
//   force_on    : keep clock running
//   activity    : traffic present this cycle
//   wake_req    : level request for a running clock
//   wake_ack    : clock running and settled while wake_req is held
//   clk_en      : registered gate enable for the gating cell
//   gated       : 1 while the clock is stopped
module phy_clk_gate_chan
    import phy_clk_gate_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned WAKE_DLY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] idle_limit,
    input  logic             force_on,
    input  logic             activity,
    input  logic             wake_req,
    output logic             wake_ack,
    output logic             clk_en,
    output logic             gated
);

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_DLY - 1);

    cg_state_t        state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             clk_en_nxt, gated_nxt, wake_ack_nxt;
    logic             busy;
    logic [CNT_W:0]   cnt_inc;

    assign busy    = activity | wake_req | force_on;
    // One bit wider so the compare against idle_limit cannot wrap at all-ones.
    assign cnt_inc = {1'b0, cnt_q} + 1'b1;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CG_RST_STATE;
            cnt_q    <= '0;
            clk_en   <= 1'b1;
            gated    <= 1'b0;
            wake_ack <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            clk_en   <= clk_en_nxt;
            gated    <= gated_nxt;
            wake_ack <= wake_ack_nxt;
        end
    end

    // Next state and counter
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            CG_ON: begin
                if (busy || idle_limit == '0) begin
                    cnt_nxt = '0;
                end else if (cnt_inc >= {1'b0, idle_limit}) begin
                    state_nxt = CG_OFF;
                    cnt_nxt   = '0;
                end else if (cnt_q != '1) begin
                    cnt_nxt = cnt_inc[CNT_W-1:0];
                end
            end
            CG_OFF: begin
                cnt_nxt = '0;
                if (busy) begin
                    state_nxt = CG_WAKE;
                end
            end
            CG_WAKE: begin
                // Not abortable: runs to completion regardless of busy.
                if (cnt_q >= WAKE_LAST) begin
                    state_nxt = CG_ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                state_nxt = CG_RST_STATE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Registered outputs are derived from the state being entered.
    always_comb begin
        clk_en_nxt   = (state_nxt != CG_OFF);
        gated_nxt    = (state_nxt == CG_OFF);
        wake_ack_nxt = (state_nxt == CG_ON) && wake_req;
    end

endmodule : phy_clk_gate_chan

// File: rtl/phy_clk_gate_ctrl.sv
// phy_clk_gate_ctrl
//   Multi-channel clock-gate controller. Each channel is an independent
//   phy_clk_gate_chan; this level is wiring only.
// Ports
//   clk, reset  : PHY clock, synchronous active-high reset
//   idle_limit  : idle cycles before gating, 0 disables auto-gating (all channels)
//   force_on    : per channel keep-on
//   activity    : per channel traffic indication
//   wake_req    : per channel wake request (level)
//   wake_ack    : per channel wake acknowledge
//   clk_en      : per channel registered gate enable
//   gated       : per channel stopped status
module phy_clk_gate_ctrl
    import phy_clk_gate_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned WAKE_DLY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  idle_limit,
    input  logic [NUM_CH-1:0] force_on,
    input  logic [NUM_CH-1:0] activity,
    input  logic [NUM_CH-1:0] wake_req,
    output logic [NUM_CH-1:0] wake_ack,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] gated
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        phy_clk_gate_chan #(
            .CNT_W    (CNT_W),
            .WAKE_DLY (WAKE_DLY)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .idle_limit (idle_limit),
            .force_on   (force_on[i]),
            .activity   (activity[i]),
            .wake_req   (wake_req[i]),
            .wake_ack   (wake_ack[i]),
            .clk_en     (clk_en[i]),
            .gated      (gated[i])
        );
    end

endmodule : phy_clk_gate_ctrl

// File: tb/tb_phy_clk_gate_ctrl.sv
module tb_phy_clk_gate_ctrl;

    localparam int NCH = 4;
    localparam int WD  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [7:0]     idle_limit;
    logic [NCH-1:0] force_on, activity, wake_req;
    logic [NCH-1:0] wake_ack, clk_en, gated;

    int n_tests = 0;
    int n_fail  = 0;

    phy_clk_gate_ctrl #(
        .NUM_CH   (NCH),
        .CNT_W    (8),
        .WAKE_DLY (WD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .idle_limit (idle_limit),
        .force_on   (force_on),
        .activity   (activity),
        .wake_req   (wake_req),
        .wake_ack   (wake_ack),
        .clk_en     (clk_en),
        .gated      (gated)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behavioural model: a channel is either stopped, settling for a number of
    // remaining cycles, or running with an idle run length.
    bit             model_on = 1'b0;
    bit             m_stopped [NCH];
    int             m_wake_left [NCH];
    int             m_idle [NCH];
    logic [NCH-1:0] exp_clk_en, exp_gated, exp_ack;

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                m_stopped[i]   = 1'b0;
                m_wake_left[i] = 0;
                m_idle[i]      = 0;
            end else if (m_stopped[i]) begin
                if (activity[i] || wake_req[i] || force_on[i]) begin
                    m_stopped[i]   = 1'b0;
                    m_wake_left[i] = WD;
                end
            end else if (m_wake_left[i] > 0) begin
                m_wake_left[i] = m_wake_left[i] - 1;
            end else if (activity[i] || wake_req[i] || force_on[i] || idle_limit == 0) begin
                m_idle[i] = 0;
            end else if (m_idle[i] + 1 >= int'(idle_limit)) begin
                m_stopped[i] = 1'b1;
                m_idle[i]    = 0;
            end else begin
                m_idle[i] = (m_idle[i] + 1 > 255) ? 255 : m_idle[i] + 1;
            end
            exp_clk_en[i] = !m_stopped[i];
            exp_gated[i]  = m_stopped[i];
            exp_ack[i]    = !reset && !m_stopped[i] && m_wake_left[i] == 0 && wake_req[i];
        end
        model_on = 1'b1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("model clk_en", int'(clk_en), int'(exp_clk_en));
            check("model gated", int'(gated), int'(exp_gated));
            check("model wake_ack", int'(wake_ack), int'(exp_ack));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gate(input int ch, input int cap, output int n);
        n = 0;
        while (gated[ch] == 1'b0 && n < cap) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset(input logic [7:0] lim);
        reset = 1'b1;
        tick(1);
        reset      = 1'b0;
        idle_limit = lim;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset      = 1'b1;
        idle_limit = 8'd16;
        force_on   = '0;
        activity   = '0;
        wake_req   = '0;

        // 1. reset values, and reset holds them against busy inputs
        tick(3);
        check("rst clk_en", int'(clk_en), 15);
        check("rst gated", int'(gated), 0);
        check("rst wake_ack", int'(wake_ack), 0);
        activity = 4'hF;
        wake_req = 4'hF;
        tick(2);
        check("rst busy clk_en", int'(clk_en), 15);
        check("rst busy wake_ack", int'(wake_ack), 0);
        activity = '0;
        wake_req = '0;

        // 2. auto-gate after 16 idle cycles
        reset = 1'b0;
        wait_gate(0, 100, n);
        check("autogate cycles", n, 16);
        check("autogate clk_en0", int'(clk_en[0]), 0);
        check("autogate gated0", int'(gated[0]), 1);

        // 3. wake latency on ch1
        wake_req[1] = 1'b1;
        tick(1);
        check("wake clk_en1", int'(clk_en[1]), 1);
        check("wake gated1", int'(gated[1]), 0);
        check("wake ack early", int'(wake_ack[1]), 0);
        tick(1);
        check("wake ack early2", int'(wake_ack[1]), 0);
        tick(1);
        check("wake ack", int'(wake_ack[1]), 1);
        tick(3);
        check("wake ack held", int'(wake_ack[1]), 1);
        check("wake no gate", int'(gated[1]), 0);
        wake_req[1] = 1'b0;
        tick(1);
        check("wake ack drop", int'(wake_ack[1]), 0);

        // 4a. idle_limit 0 never gates
        do_reset(8'd0);
        tick(1000);
        check("lim0 gated", int'(gated), 0);
        check("lim0 clk_en", int'(clk_en), 15);

        // 4b. idle_limit 255
        do_reset(8'd255);
        wait_gate(0, 400, n);
        check("lim255 cycles", n, 255);

        // 4c. limit cut from 200 to 5 at count 50
        do_reset(8'd200);
        tick(50);
        check("cut pre gated", int'(gated[0]), 0);
        idle_limit = 8'd5;
        tick(1);
        check("cut gated", int'(gated[0]), 1);

        // 5a. activity on the would-be gating cycle
        do_reset(8'd16);
        tick(15);
        activity[2] = 1'b1;
        tick(1);
        check("race gated0", int'(gated[0]), 1);
        check("race gated2", int'(gated[2]), 0);
        check("race clk_en2", int'(clk_en[2]), 1);
        activity[2] = 1'b0;
        wait_gate(2, 100, n);
        check("race regate cycles", n, 16);

        // 5b. force_on during WAKE on ch3
        wake_req[3] = 1'b1;
        tick(1);
        force_on[3] = 1'b1;
        wake_req[3] = 1'b0;
        tick(2);
        check("force clk_en3", int'(clk_en[3]), 1);
        tick(100);
        check("force held gated3", int'(gated[3]), 0);
        force_on[3] = 1'b0;

        // 6. reset while ch0 is in WAKE
        check("midrst pre gated0", int'(gated[0]), 1);
        wake_req[0] = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        check("midrst clk_en0", int'(clk_en[0]), 1);
        check("midrst ack0", int'(wake_ack[0]), 0);
        check("midrst gated0", int'(gated[0]), 0);
        reset = 1'b0;
        tick(1);
        check("midrst ack after", int'(wake_ack[0]), 1);
        wake_req[0] = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_phy_clk_gate_ctrl
